alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
- Initiator side of the ALU core command interface (en / cmd / da / db).
- Fetches instruction words from a synchronous program memory and decodes them into cmd plus source/destination register indices.
- Reads operands from a local 4-entry register file, issues one single-cycle command per instruction to the ALU core, and waits for the result.
- Writes the result back to the register file, then advances the PC. Sits between program memory and the ALU core of the simple MCU.

Parameters:
- I_BW, 4, instruction (ALU command) bandwidth.
- D_BW, 4, data bandwidth.
- PC_BW, 4, program counter width; program depth is 2**PC_BW.
- TO_CYC, 8, maximum cycles waited for alu_vld before error.
- Derived, not overridable: RA_BW = 2; IW = I_BW + 3*RA_BW. Instruction word is {cmd[I_BW], rd, ra, rb}, with cmd in the MSBs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin program execution at PC 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the program ends (HALT, PC wrap or timeout).
- err  out  1  sticky timeout flag.
- pm_rd  out  1  program memory read strobe.
- pm_addr  out  PC_BW  program memory address.
- pm_data  in  IW  read data, valid the cycle after pm_rd.
- alu_en  out  1  command valid, exactly one cycle per instruction.
- alu_cmd  out  I_BW  command.
- alu_da  out  D_BW  operand A.
- alu_db  out  D_BW  operand B.
- alu_res  in  D_BW  ALU result.
- alu_vld  in  1  result valid.
- dbg_addr  in  RA_BW  register file debug read index.
- dbg_data  out  D_BW  rf[dbg_addr], combinational.

Behaviour:
- Reset state: all outputs 0, state IDLE, PC 0, all rf entries 0, err 0, timeout counter 0. Reset wins over every other event in the same cycle. Reset mid-operation abandons the instruction with no writeback.
- Outputs: alu_*, pm_addr and done are registered. pm_rd is high exactly while state == FETCH, and pm_addr = PC in that cycle.
- FSM transitions:
  - IDLE: start=1 -> PC<=0, err<=0, go to FETCH. start while busy is ignored.
  - FETCH: pm_rd=1 -> LOAD.
  - LOAD: IR<=pm_data. If cmd == HALT_OP (all ones) -> DONE, otherwise -> ISSUE. HALT is never sent to the ALU.
  - ISSUE: alu_en=1, alu_cmd=IR.cmd, alu_da=rf[ra], alu_db=rf[rb] in this cycle. Clear timeout counter -> WAIT_RES.
  - WAIT_RES:
    - alu_vld=1: rf[rd]<=alu_res. If PC == 2**PC_BW-1 -> DONE (no wrap to 0); otherwise PC<=PC+1 -> FETCH.
    - Else the counter increments. When it reaches TO_CYC-1 with no alu_vld: err<=1 -> DONE, no writeback.
    - alu_vld in the same cycle the counter reaches its limit: valid wins.
  - DONE: done=1 for one cycle -> IDLE.
- Operand reads and write-back:
  - alu_vld outside WAIT_RES is ignored. The ALU's minimum latency is 1 cycle after alu_en.
  - ra == rb is legal, and both operands get the same value.
  - rd equal to ra or rb: the next instruction sees the new value, because writeback completes before its ISSUE.
- Outside ISSUE: alu_en=0; alu_cmd, alu_da and alu_db hold their last issued values.
- Latency: 4 cycles per instruction with a 1-cycle ALU (FETCH, LOAD, ISSUE, WAIT_RES). From start to the first alu_en is 3 cycles.
- Width: result is written as D_BW bits. No arithmetic is performed here except PC+1 (PC_BW) and the timeout counter (clog2(TO_CYC)).
- err stays set until the next accepted start.

Decomposition:
- Package alu_cmd_seq_pkg holds:
  - state enum (IDLE, FETCH, LOAD, ISSUE, WAIT_RES, DONE);
  - HALT_OP constant;
  - RA_BW;
  - field-extract functions for cmd, rd, ra and rb.
- Sub-module alu_seq_rf: 4 x D_BW register file with 2 combinational read ports, 1 debug read port, a synchronous write port and synchronous clear on rst.

Test Plan:
- Program {cmd=3,rd=1,ra=0,rb=0}, HALT; ALU echoes 4'h5 one cycle after alu_en -> single alu_en pulse with cmd=3, da=db=0; rf[1]=5; done 1 cycle after HALT is fetched; err=0.
- Dependent chain: rd=2 from op1 result 7, then op2 with ra=2 -> op2 alu_da=7; alu_en pulses 4 cycles apart.
- ALU never asserts alu_vld with TO_CYC=8 -> err=1, done pulses, rf unchanged, busy=0 afterwards; next start clears err.
- alu_vld arrives on the exact timeout cycle -> writeback occurs and err=0. Stray alu_vld in IDLE/FETCH -> no rf change.
- 16 non-HALT instructions -> 16 alu_en pulses, done after PC 15, pm_addr never returns to 0. start pulsed mid-run -> ignored.
- rst asserted during WAIT_RES -> next cycle: busy=0, alu_en=0, all rf entries 0, PC 0; later alu_vld is ignored.

Source files
------------

// File: rtl/alu_cmd_seq_pkg.sv
// Shared types and instruction-field helpers for the ALU command sequencer.
// Instruction word layout is {cmd, rd, ra, rb} with cmd in the MSBs.
package alu_cmd_seq_pkg;

  localparam int RA_BW = 2;

  // HALT is the all-ones command; users slice the low I_BW bits.
  localparam logic [31:0] HALT_OP = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT_RES,
    DONE
  } state_t;

  // Helpers take a zero-extended instruction word so they work for any I_BW.
  function automatic logic [31:0] instr_cmd(input logic [31:0] instr);
    return instr >> (3 * RA_BW);
  endfunction

  function automatic logic [RA_BW-1:0] instr_rd(input logic [31:0] instr);
    return instr[2*RA_BW +: RA_BW];
  endfunction

  function automatic logic [RA_BW-1:0] instr_ra(input logic [31:0] instr);
    return instr[RA_BW +: RA_BW];
  endfunction

  function automatic logic [RA_BW-1:0] instr_rb(input logic [31:0] instr);
    return instr[0 +: RA_BW];
  endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// 4-entry register file: two combinational operand reads, one debug read,
// one synchronous write port, cleared synchronously by rst.
module alu_seq_rf
  import alu_cmd_seq_pkg::*;
#(
  parameter int D_BW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RA_BW-1:0] wa,
  input  logic [D_BW-1:0]  wd,
  input  logic [RA_BW-1:0] ra_a,
  output logic [D_BW-1:0]  rd_a,
  input  logic [RA_BW-1:0] ra_b,
  output logic [D_BW-1:0]  rd_b,
  input  logic [RA_BW-1:0] dbg_addr,
  output logic [D_BW-1:0]  dbg_data
);

  localparam int DEPTH = 2 ** RA_BW;

  logic [D_BW-1:0] entry [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [D_BW-1:0] val_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg <= '0;
      end else if (we && (wa == RA_BW'(gi))) begin
        val_reg <= wd;
      end
    end

    assign entry[gi] = val_reg;
  end

  assign rd_a     = entry[ra_a];
  assign rd_b     = entry[ra_b];
  assign dbg_data = entry[dbg_addr];

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: fetches {cmd,rd,ra,rb} words, issues one ALU command
// per instruction, waits (bounded) for the result and writes it back.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int I_BW   = 4,
  parameter int D_BW   = 4,
  parameter int PC_BW  = 4,
  parameter int TO_CYC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      pm_rd,
  output logic [PC_BW-1:0]          pm_addr,
  input  logic [I_BW+3*RA_BW-1:0]   pm_data,
  output logic                      alu_en,
  output logic [I_BW-1:0]           alu_cmd,
  output logic [D_BW-1:0]           alu_da,
  output logic [D_BW-1:0]           alu_db,
  input  logic [D_BW-1:0]           alu_res,
  input  logic                      alu_vld,
  input  logic [RA_BW-1:0]          dbg_addr,
  output logic [D_BW-1:0]           dbg_data
);

  localparam int                IW       = I_BW + 3 * RA_BW;
  localparam int                CNT_BW   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [PC_BW-1:0]  PC_LAST  = '1;
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(TO_CYC - 1);
  localparam logic [I_BW-1:0]   HALT_CMD = HALT_OP[I_BW-1:0];

  state_t            state_reg;
  logic [PC_BW-1:0]  pc_reg;
  logic [PC_BW-1:0]  pm_addr_reg;
  logic [RA_BW-1:0]  rd_reg;
  logic [CNT_BW-1:0] to_cnt_reg;
  logic              err_reg;
  logic              done_reg;
  logic              alu_en_reg;
  logic [I_BW-1:0]   alu_cmd_reg;
  logic [D_BW-1:0]   alu_da_reg;
  logic [D_BW-1:0]   alu_db_reg;

  logic [I_BW-1:0]   ld_cmd;
  logic [RA_BW-1:0]  ld_ra;
  logic [RA_BW-1:0]  ld_rb;
  logic [D_BW-1:0]   rf_da;
  logic [D_BW-1:0]   rf_db;
  logic              rf_we;
  logic [PC_BW-1:0]  pc_inc;

  // Operands are read straight off pm_data in LOAD so they are ready to be
  // registered onto alu_da/alu_db for the ISSUE cycle.
  assign ld_cmd = I_BW'(instr_cmd(32'(pm_data)));
  assign ld_ra  = instr_ra(32'(pm_data));
  assign ld_rb  = instr_rb(32'(pm_data));
  assign rf_we  = (state_reg == WAIT_RES) && alu_vld;
  assign pc_inc = pc_reg + PC_BW'(1);

  alu_seq_rf #(
    .D_BW(D_BW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .wa       (rd_reg),
    .wd       (alu_res),
    .ra_a     (ld_ra),
    .rd_a     (rf_da),
    .ra_b     (ld_rb),
    .rd_b     (rf_db),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      pm_addr_reg <= '0;
      rd_reg      <= '0;
      to_cnt_reg  <= '0;
      err_reg     <= 1'b0;
      done_reg    <= 1'b0;
      alu_en_reg  <= 1'b0;
      alu_cmd_reg <= '0;
      alu_da_reg  <= '0;
      alu_db_reg  <= '0;
    end else begin
      alu_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            pc_reg      <= '0;
            pm_addr_reg <= '0;
            err_reg     <= 1'b0;
            state_reg   <= FETCH;
          end
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          rd_reg <= instr_rd(32'(pm_data));
          if (ld_cmd == HALT_CMD) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            alu_en_reg  <= 1'b1;
            alu_cmd_reg <= ld_cmd;
            alu_da_reg  <= rf_da;
            alu_db_reg  <= rf_db;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_reg <= '0;
          state_reg  <= WAIT_RES;
        end
        WAIT_RES: begin
          // TO_CYC wait cycles are allowed; a result on the last one still counts.
          if (alu_vld) begin
            if (pc_reg == PC_LAST) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              pc_reg      <= pc_inc;
              pm_addr_reg <= pc_inc;
              state_reg   <= FETCH;
            end
          end else if (to_cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + CNT_BW'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = (state_reg != IDLE);
  assign pm_rd   = (state_reg == FETCH);
  assign pm_addr = pm_addr_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign alu_en  = alu_en_reg;
  assign alu_cmd = alu_cmd_reg;
  assign alu_da  = alu_da_reg;
  assign alu_db  = alu_db_reg;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: program memory and ALU are modelled here; expected
// behaviour comes from a sequential instruction-level model of the program.
module tb_alu_cmd_seq;

  localparam int I_BW = 4, D_BW = 4, PC_BW = 4, TO_CYC = 8;
  localparam int IW = I_BW + 6;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst, start, busy, done, err, pm_rd, alu_en, alu_vld;
  logic [PC_BW-1:0] pm_addr;
  logic [IW-1:0]    pm_data;
  logic [I_BW-1:0]  alu_cmd;
  logic [D_BW-1:0]  alu_da, alu_db, alu_res, dbg_data;
  logic [1:0]       dbg_addr;

  always #5 clk = ~clk;

  alu_cmd_seq #(.I_BW(I_BW), .D_BW(D_BW), .PC_BW(PC_BW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .pm_rd(pm_rd), .pm_addr(pm_addr), .pm_data(pm_data),
    .alu_en(alu_en), .alu_cmd(alu_cmd), .alu_da(alu_da), .alu_db(alu_db),
    .alu_res(alu_res), .alu_vld(alu_vld), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] da;
    logic [3:0] db;
    int         cyc;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  logic [IW-1:0] pm [DEPTH];
  int          dly [DEPTH];
  logic [3:0]  model_rf [4];
  logic [3:0]  rf_snap [4];
  int          fixed_res = -1;
  txn_t        obs_q[$], exp_q[$];
  int          obs_pc_q[$], exp_pc_q[$];
  int          done_cnt, done_cyc, exp_done_cyc;
  bit          exp_err;
  logic        err_first, busy_after, err_after;
  logic        rst_busy, rst_en, rst_done;
  logic [3:0]  rst_addr;

  function automatic logic [IW-1:0] mk(int cmd, int rd, int ra, int rb);
    return {4'(cmd), 2'(rd), 2'(ra), 2'(rb)};
  endfunction

  function automatic logic [IW-1:0] rand_op();
    return mk($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // Behaviour of the bench's ALU; the model uses the same arithmetic.
  function automatic logic [3:0] alu_fn(logic [3:0] c, logic [3:0] a, logic [3:0] b);
    if (fixed_res >= 0) return 4'(fixed_res);
    return 4'((a + 4'(3 * b)) ^ c);
  endfunction

  // Instruction-level model: cycle numbers are relative to the start cycle.
  task automatic model_run();
    int f = 1;
    exp_q.delete(); exp_pc_q.delete(); exp_err = 0; exp_done_cyc = -1;
    for (int pc = 0; pc < DEPTH; pc++) begin
      logic [IW-1:0] w = pm[pc];
      txn_t t;
      int issue = f + 2;
      exp_pc_q.push_back(pc);
      if (w[9:6] == 4'hF) begin exp_done_cyc = f + 2; break; end
      t.cmd = w[9:6]; t.da = model_rf[w[3:2]]; t.db = model_rf[w[1:0]]; t.cyc = issue;
      exp_q.push_back(t);
      if (dly[pc] < 1 || dly[pc] > TO_CYC) begin
        exp_err = 1; exp_done_cyc = issue + TO_CYC + 1; break;
      end
      model_rf[w[5:4]] = alu_fn(t.cmd, t.da, t.db);
      if (pc == DEPTH - 1) begin exp_done_cyc = issue + dly[pc] + 1; break; end
      f = issue + dly[pc] + 1;
    end
  endtask

  // Starts the program and plays memory + ALU until one cycle after done.
  task automatic run_prog(input bit stray, input bit mid_start, input int rst_cyc);
    int wait_cnt = 0;
    int idx = 0;
    logic [3:0] pend = '0;
    obs_q.delete(); obs_pc_q.delete(); done_cnt = 0; done_cyc = -1;
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0; alu_vld = 1'b0;
      if (cyc == 1) err_first = err;
      if (cyc == rst_cyc) rst = 1'b1;
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        rst = 1'b0;
        rst_busy = busy; rst_en = alu_en; rst_done = done; rst_addr = pm_addr;
        break;
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin alu_vld = 1'b1; alu_res = pend; end
      end
      if (alu_en === 1'b1) begin
        txn_t t;
        t.cmd = alu_cmd; t.da = alu_da; t.db = alu_db; t.cyc = cyc;
        obs_q.push_back(t);
        wait_cnt = (idx < DEPTH) ? dly[idx] : 0;
        idx++;
        pend = alu_fn(alu_cmd, alu_da, alu_db);
      end
      if (pm_rd === 1'b1) begin
        obs_pc_q.push_back(int'(pm_addr));
        pm_data = pm[pm_addr];
        if (stray && !alu_vld) begin alu_vld = 1'b1; alu_res = 4'($urandom); end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (mid_start && busy === 1'b1 && done !== 1'b1 && $urandom_range(0, 3) == 0) start = 1'b1;
      if (done_cyc >= 0 && cyc > done_cyc) break;
    end
    alu_vld = 1'b0; start = 1'b0;
    busy_after = busy; err_after = err;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) begin pm[i] = mk(15, 0, 0, 0); dly[i] = 1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_vld = 1'b0; alu_res = '0; pm_data = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, alu_en, pm_rd, pm_addr, alu_cmd, alu_da, alu_db} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b required all zero",
               {busy, done, err, alu_en, pm_rd, pm_addr, alu_cmd, alu_da, alu_db});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_rf[i] = '0; dbg_addr = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'h0) begin errors++; $display("FAIL reset_rf[%0d] got %h required 0", i, dbg_data); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    clear_prog(); fixed_res = 5;
    pm[0] = mk(3, 1, 0, 0);
    model_run(); run_prog(0, 0, -1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL single_en_count got %0d required 1", obs_q.size());
    end else begin
      checks++;
      if ({obs_q[0].cmd, obs_q[0].da, obs_q[0].db} !== 12'h300 || obs_q[0].cyc != 3) begin
        errors++;
        $display("FAIL single_issue got cmd=%h da=%h db=%h cyc=%0d required cmd=3 da=0 db=0 cyc=3",
                 obs_q[0].cmd, obs_q[0].da, obs_q[0].db, obs_q[0].cyc);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != exp_done_cyc) begin
      errors++; $display("FAIL single_done got cnt=%0d cyc=%0d required cnt=1 cyc=%0d", done_cnt, done_cyc, exp_done_cyc);
    end
    checks++;
    if (err_after !== 1'b0 || busy_after !== 1'b0) begin
      errors++; $display("FAIL single_end got err=%b busy=%b required 0 0", err_after, busy_after);
    end
    dbg_addr = 2'd1; #1;
    checks++;
    if (dbg_data !== 4'h5) begin errors++; $display("FAIL single_rf1 got %h required 5", dbg_data); end
    $display("test_single cmd=3 result=5 done_cyc=%0d", done_cyc);
  endtask

  task automatic test_chain();
    clear_prog(); fixed_res = 7;
    pm[0] = mk(1, 2, 0, 1);
    pm[1] = mk(2, 3, 2, 0);
    model_run(); run_prog(0, 0, -1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL chain_en_count got %0d required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].da !== 4'h7) begin errors++; $display("FAIL chain_da got %h required 7", obs_q[1].da); end
      checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 4) begin
        errors++; $display("FAIL chain_gap got %0d required 4", obs_q[1].cyc - obs_q[0].cyc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      checks++;
      if (dbg_data !== model_rf[i]) begin errors++; $display("FAIL chain_rf[%0d] got %h required %h", i, dbg_data, model_rf[i]); end
    end
    fixed_res = -1;
    $display("test_chain en_pulses=%0d", obs_q.size());
  endtask

  task automatic test_timeout();
    clear_prog();
    pm[0] = rand_op(); dly[0] = 0;
    for (int i = 0; i < 4; i++) rf_snap[i] = model_rf[i];
    model_run(); run_prog(0, 0, -1);
    checks++;
    if (err_after !== 1'b1 || done_cnt != 1 || done_cyc != exp_done_cyc || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL timeout got err=%b done_cnt=%0d done_cyc=%0d busy=%b required 1 1 %0d 0",
               err_after, done_cnt, done_cyc, busy_after, exp_done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      checks++;
      if (dbg_data !== rf_snap[i]) begin errors++; $display("FAIL timeout_rf[%0d] got %h required %h", i, dbg_data, rf_snap[i]); end
    end
    clear_prog();
    model_run(); run_prog(0, 0, -1);
    checks++;
    if (err_first !== 1'b0 || err_after !== 1'b0) begin
      errors++; $display("FAIL err_clear got first=%b after=%b required 0 0", err_first, err_after);
    end
    $display("test_timeout done_cyc=%0d", exp_done_cyc);
  endtask

  task automatic test_exact_timeout();
    for (int k = 0; k < 2; k++) begin
      clear_prog();
      pm[0] = rand_op(); dly[0] = TO_CYC + k;
      model_run(); run_prog(0, 0, -1);
      checks++;
      if (err_after !== exp_err || done_cyc != exp_done_cyc) begin
        errors++; $display("FAIL edge_timeout[%0d] got err=%b done_cyc=%0d required %b %0d",
                           k, err_after, done_cyc, exp_err, exp_done_cyc);
      end
      for (int i = 0; i < 4; i++) begin
        dbg_addr = 2'(i); #1;
        checks++;
        if (dbg_data !== model_rf[i]) begin errors++; $display("FAIL edge_rf[%0d] got %h required %h", i, dbg_data, model_rf[i]); end
      end
    end
    repeat (3) begin @(negedge clk); alu_vld = 1'b1; alu_res = 4'($urandom); end
    @(negedge clk); alu_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      checks++;
      if (dbg_data !== model_rf[i]) begin errors++; $display("FAIL idle_stray_rf[%0d] got %h required %h", i, dbg_data, model_rf[i]); end
    end
    $display("test_exact_timeout done");
  endtask

  task automatic test_program(input int n_iter, input bit full, input string name);
    for (int it = 0; it < n_iter; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pm[i]  = (!full && $urandom_range(0, 7) == 0) ? mk(15, 0, 0, 0) : rand_op();
        dly[i] = full ? $urandom_range(1, 3) : $urandom_range(1, TO_CYC + 1);
      end
      model_run(); run_prog(1'($urandom_range(0, 1)) | full, 1'($urandom_range(0, 1)) | full, -1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL %s_en_count got %0d required %0d", name, obs_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (obs_q[k] != exp_q[k]) begin
            errors++;
            $display("FAIL %s_issue[%0d] got cmd=%h da=%h db=%h cyc=%0d required cmd=%h da=%h db=%h cyc=%0d",
                     name, k, obs_q[k].cmd, obs_q[k].da, obs_q[k].db, obs_q[k].cyc,
                     exp_q[k].cmd, exp_q[k].da, exp_q[k].db, exp_q[k].cyc);
          end
        end
      end
      checks++;
      if (obs_pc_q != exp_pc_q) begin
        errors++; $display("FAIL %s_pc_seq got %0d fetches required %0d", name, obs_pc_q.size(), exp_pc_q.size());
      end
      checks++;
      if (done_cnt != 1 || done_cyc != exp_done_cyc || err_after !== exp_err || busy_after !== 1'b0) begin
        errors++;
        $display("FAIL %s_end got done_cnt=%0d done_cyc=%0d err=%b busy=%b required 1 %0d %b 0",
                 name, done_cnt, done_cyc, err_after, busy_after, exp_done_cyc, exp_err);
      end
      for (int i = 0; i < 4; i++) begin
        dbg_addr = 2'(i); #1;
        checks++;
        if (dbg_data !== model_rf[i]) begin errors++; $display("FAIL %s_rf[%0d] got %h required %h", name, i, dbg_data, model_rf[i]); end
      end
      $display("%s iter=%0d issues=%0d err=%b done_cyc=%0d", name, it, obs_q.size(), exp_err, done_cyc);
    end
  endtask

  task automatic test_rst_wait();
    clear_prog();
    pm[0] = rand_op(); pm[1] = rand_op(); dly[0] = 1; dly[1] = 0;
    run_prog(0, 0, 9);
    checks++;
    if ({rst_busy, rst_en, rst_done, rst_addr} !== 7'd0) begin
      errors++; $display("FAIL rst_wait got busy=%b en=%b done=%b pm_addr=%h required 0 0 0 0",
                         rst_busy, rst_en, rst_done, rst_addr);
    end
    repeat (2) begin alu_vld = 1'b1; alu_res = 4'hF; @(negedge clk); end
    alu_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_rf[i] = '0; dbg_addr = 2'(i); #1;
      checks++;
      if (dbg_data !== 4'h0) begin errors++; $display("FAIL rst_wait_rf[%0d] got %h required 0", i, dbg_data); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got %b required 0", busy); end
    clear_prog();
    model_run(); run_prog(0, 0, -1);
    checks++;
    if (obs_pc_q.size() != 1 || obs_pc_q[0] != 0 || done_cyc != exp_done_cyc) begin
      errors++; $display("FAIL rst_wait_restart got fetches=%0d done_cyc=%0d required 1 %0d",
                         obs_pc_q.size(), done_cyc, exp_done_cyc);
    end
    $display("test_rst_wait done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_timeout();
    test_exact_timeout();
    test_program(1, 1'b1, "full_run");
    test_program(6, 1'b0, "random");
    test_rst_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
